// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU execution unit with a valid/ready result handshake; shifts iterate one bit per cycle.
// Define ALU_BARREL_SHIFT_EN to compute shifts in a single cycle instead (no SHIFT state or counter).
module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [4:0]       aluop_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             err_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b10010;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLT  = 5'b00011;
    localparam logic [4:0] OP_SLTU = 5'b00101;
    localparam logic [4:0] OP_SLL  = 5'b00111;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b01000;

`ifdef ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};
`endif

    // Single-cycle result; in the iterative build a shift reaching here has amount 0, so it passes A.
    function automatic logic [WIDTH-1:0] alu_result(
        input logic [4:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_XOR:  res = a ^ b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL:  res = a << b[SHW-1:0];
            OP_SRL:  res = a >> b[SHW-1:0];
            OP_SRA:  res = $signed(a) >>> b[SHW-1:0];
`else
            OP_SLL:  res = a;
            OP_SRL:  res = a;
            OP_SRA:  res = a;
`endif
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    function automatic logic alu_unsupported(input logic [4:0] op);
        logic bad;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR,
            OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA: bad = 1'b0;
            default:                                 bad = 1'b1;
        endcase
        return bad;
    endfunction

`ifndef ALU_BARREL_SHIFT_EN
    function automatic logic [WIDTH-1:0] shift_by_one(
        input logic [4:0]       op,
        input logic [WIDTH-1:0] w
    );
        logic [WIDTH-1:0] res;
        case (op)
            OP_SLL:  res = {w[WIDTH-2:0], 1'b0};
            OP_SRL:  res = {1'b0, w[WIDTH-1:1]};
            OP_SRA:  res = {w[WIDTH-1], w[WIDTH-1:1]};
            default: res = w;
        endcase
        return res;
    endfunction
`endif

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;
    logic             r_valid;
    logic [WIDTH-1:0] w_alu;
    logic             w_unsup;
    logic             w_start_shift;

`ifndef ALU_BARREL_SHIFT_EN
    logic [4:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] w_shift1;
    logic             w_is_shift;

    assign w_is_shift    = (aluop_i == OP_SLL) || (aluop_i == OP_SRL) || (aluop_i == OP_SRA);
    assign w_start_shift = w_is_shift && (op_b_i[SHW-1:0] != {SHW{1'b0}});
    assign w_shift1      = shift_by_one(r_op, r_work);
`else
    assign w_start_shift = 1'b0;
`endif

    assign w_alu   = alu_result(aluop_i, op_a_i, op_b_i);
    assign w_unsup = alu_unsupported(aluop_i);

    assign ready_o  = (r_state == ST_IDLE);
    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign zero_o   = r_zero;
    assign err_o    = r_err;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    if (w_start_shift) begin
`ifndef ALU_BARREL_SHIFT_EN
                        w_next_state = ST_SHIFT;
`else
                        w_next_state = ST_DONE;
`endif
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
                if (r_cnt == CNT_ONE) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
`endif
            ST_DONE: begin
                if (ready_i) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate shifts, hold the result through DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result <= {WIDTH{1'b0}};
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            r_op     <= 5'b00000;
            r_work   <= {WIDTH{1'b0}};
            r_cnt    <= {SHW{1'b0}};
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
`ifndef ALU_BARREL_SHIFT_EN
                        r_op   <= aluop_i;
                        r_work <= op_a_i;
                        r_cnt  <= op_b_i[SHW-1:0];
`endif
                        if (!w_start_shift) begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == {WIDTH{1'b0}});
                            r_err    <= w_unsup;
                            r_valid  <= 1'b1;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                ST_SHIFT: begin
                    r_work <= w_shift1;
                    r_cnt  <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_result <= w_shift1;
                        r_zero   <= (w_shift1 == {WIDTH{1'b0}});
                        r_err    <= 1'b0;
                        r_valid  <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec; expected latencies follow ALU_BARREL_SHIFT_EN.
module tb_alu_seq_exec;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [4:0]  aluop_i = 5'b00000;
    logic [31:0] op_a_i = 32'd0;
    logic [31:0] op_b_i = 32'd0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;
    logic        zero_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_exec #(.WIDTH(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .aluop_i  (aluop_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic int shift_lat(input int amt);
        if (BARREL || amt == 0) return 1;
        return amt + 1;
    endfunction

    // Issue one op from IDLE, measure latency, check the result, then complete the handshake.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z,
                          input logic exp_e, input int exp_lat);
        int lat;
        check_val({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
        valid_i = 1'b1;
        aluop_i = op;
        op_a_i  = a;
        op_b_i  = b;
        @(negedge clk_i);
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 64) begin
            @(negedge clk_i);
            lat++;
        end
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_res"}, result_o, exp_r);
        check_val({tag, "_zero"}, {31'd0, zero_o}, {31'd0, exp_z});
        check_val({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_e});
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check_val({tag, "_vdrop"}, {31'd0, valid_o}, 32'd0);
        check_val({tag, "_edrop"}, {31'd0, err_o}, 32'd0);
        check_val({tag, "_hold"}, result_o, exp_r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        check_val("rst_valid", {31'd0, valid_o}, 32'd0);
        check_val("rst_ready", {31'd0, ready_o}, 32'd1);
        check_val("rst_result", result_o, 32'd0);
        check_val("rst_zero", {31'd0, zero_o}, 32'd0);
        check_val("rst_err", {31'd0, err_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_op("add",   5'b00010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1);
        run_op("sub",   5'b10010, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
        run_op("sub0",  5'b10010, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1);
        run_op("slt",   5'b00011, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
        run_op("sltu",  5'b00101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
        run_op("xor",   5'b00100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1'b0, 1);
        run_op("and",   5'b00000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 1);
        run_op("or",    5'b00001, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1);
        run_op("sra4",  5'b01000, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, shift_lat(4));
        run_op("sll3",  5'b00111, 32'd1, 32'h0000_0023, 32'd8, 1'b0, 1'b0, shift_lat(3));
        run_op("srl0",  5'b00110, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 1);
        run_op("srl31", 5'b00110, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0, shift_lat(31));
        run_op("bad",   5'b11111, 32'hDEAD_BEEF, 32'd9, 32'd0, 1'b1, 1'b1, 1);

        // Backpressure: new requests are ignored while the result is held in DONE.
        valid_i = 1'b1; aluop_i = 5'b00010; op_a_i = 32'd10; op_b_i = 32'd20;
        @(negedge clk_i);
        aluop_i = 5'b10010; op_a_i = 32'd100; op_b_i = 32'd1;
        check_val("bp_first_valid", {31'd0, valid_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_val("bp_hold_res", result_o, 32'd30);
            check_val("bp_hold_rdy", {31'd0, ready_o}, 32'd0);
            check_val("bp_hold_vld", {31'd0, valid_o}, 32'd1);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check_val("bp_idle_rdy", {31'd0, ready_o}, 32'd1);
        check_val("bp_idle_vld", {31'd0, valid_o}, 32'd0);
        check_val("bp_idle_res", result_o, 32'd30);
        @(negedge clk_i);
        valid_i = 1'b0;
        check_val("bp_next_vld", {31'd0, valid_o}, 32'd1);
        check_val("bp_next_res", result_o, 32'd99);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;

        // Abort a long shift with reset partway through.
        valid_i = 1'b1; aluop_i = 5'b00111; op_a_i = 32'd1; op_b_i = 32'd31;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        if (!BARREL) begin
            check_val("abort_pre_vld", {31'd0, valid_o}, 32'd0);
            check_val("abort_pre_rdy", {31'd0, ready_o}, 32'd0);
        end
        rst_ni = 1'b0;
        #1;
        check_val("abort_vld", {31'd0, valid_o}, 32'd0);
        check_val("abort_rdy", {31'd0, ready_o}, 32'd1);
        check_val("abort_res", result_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_val("abort_post_vld", {31'd0, valid_o}, 32'd0);
        run_op("add_after", 5'b00010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
